// File: rtl/ws2812_serializer.sv
// ws2812_serializer: pulls LEDS*3 bytes from upstream and drives them MSB-first as WS2812 NRZ pulses, then a low latch period.
module ws2812_serializer #(
  parameter int LEDS         = 128,
  parameter int T_BIT        = 15,
  parameter int T0H          = 4,
  parameter int T1H          = 8,
  parameter int RESET_CYCLES = 720
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [7:0] color,
  output logic       data_request,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);
  localparam int NB = LEDS * 3;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int PW = $clog2(T_BIT);
  localparam int LW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
  state_t state, n_state;
  logic [7:0] shreg, n_shreg;
  logic [BW-1:0] byte_cnt, n_byte;
  logic [2:0] bit_cnt, n_bit;
  logic [PW-1:0] phase, n_phase;
  logic [LW-1:0] latch_cnt, n_latch;
  logic n_busy, req, n_dout;
  assign data_request = req & rst;
  always_comb begin
    n_state = state;
    n_shreg = shreg;
    n_byte = byte_cnt;
    n_bit = bit_cnt;
    n_phase = phase;
    n_latch = latch_cnt;
    n_busy = busy;
    req = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (trigger) begin
        req = 1'b1;
        n_shreg = color;
        n_byte = '0;
        n_bit = '0;
        n_phase = '0;
        n_busy = 1'b1;
        n_state = SEND;
      end
      SEND: if (phase == PW'(T_BIT - 1)) begin
        n_phase = '0;
        n_shreg = shreg << 1;
        n_bit = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (byte_cnt < BW'(NB - 1)) begin
            req = 1'b1;
            n_shreg = color;
            n_byte = byte_cnt + BW'(1);
          end else begin
            n_state = LATCH;
            n_latch = '0;
          end
        end
      end else n_phase = phase + PW'(1);
      LATCH: if (latch_cnt == LW'(RESET_CYCLES - 1)) begin
        frame_done = 1'b1;
        n_busy = 1'b0;
        n_state = IDLE;
      end else n_latch = latch_cnt + LW'(1);
      default: n_state = IDLE;
    endcase
    // line level is computed from next-state so the first high cycle follows the capture edge
    n_dout = (n_state == SEND) && (n_phase < (n_shreg[7] ? PW'(T1H) : PW'(T0H)));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      byte_cnt <= '0;
      bit_cnt <= '0;
      phase <= '0;
      latch_cnt <= '0;
      busy <= 1'b0;
      dout <= 1'b0;
    end else begin
      state <= n_state;
      shreg <= n_shreg;
      byte_cnt <= n_byte;
      bit_cnt <= n_bit;
      phase <= n_phase;
      latch_cnt <= n_latch;
      busy <= n_busy;
      dout <= n_dout;
    end
  end
endmodule

// File: tb/tb_ws2812_serializer.sv
// tb_ws2812_serializer: upstream byte model feeds a scoreboard; a line decoder rebuilds bytes from pulse widths and compares.
module tb_ws2812_serializer;
  localparam int LEDS = 16, T_BIT = 15, T0H = 4, T1H = 8, RC = 720;
  localparam int NB = LEDS * 3;
  logic clk = 0, rst = 0, trigger = 0;
  logic [7:0] color = 8'hA5;
  logic data_request, dout, busy, frame_done;
  int tests = 0, fails = 0, cyc = 0, req_in_frame = 0, t_start = 0;
  logic [7:0] q[$];
  ws2812_serializer #(.LEDS(LEDS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .color(color),
    .data_request(data_request), .dout(dout), .busy(busy), .frame_done(frame_done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [7:0] col(input int i);
    int v;
    v = i * 37 + 11;
    return i == 0 ? 8'hA5 : i == 1 ? 8'h00 : i == 2 ? 8'hFF : v[7:0];
  endfunction
  // upstream: hands out col(idx) per request, restarting the sequence each frame and on reset
  initial begin
    int idx = 0;
    logic prev_req = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        idx = 0;
        color = col(0);
        req_in_frame = 0;
        prev_req = 0;
      end else begin
        if (data_request && prev_req) chk("req_back_to_back", 1, 0);
        prev_req = data_request;
        if (frame_done) begin
          chk("req_count", req_in_frame, NB);
          chk("frame_len", cyc - t_start, NB * 8 * T_BIT + RC);
          req_in_frame = 0;
          idx = 0;
          color = col(0);
        end
        if (data_request) begin
          if (req_in_frame == 0) t_start = cyc;
          q.push_back(color);
          req_in_frame++;
          idx++;
          @(posedge clk);
          #1 color = col(idx);
        end
      end
    end
  end
  // line decoder: pulse width gives the bit, rising edges must be T_BIT apart within a frame
  initial begin
    int hi = 0, nb = 0, last_rise = 0;
    logic pd = 0, have_rise = 0;
    logic [7:0] sh = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hi = 0; nb = 0; pd = 0; have_rise = 0;
        q.delete();
      end else begin
        if (dout && !pd) begin
          if (have_rise) chk("rise_gap", cyc - last_rise, T_BIT);
          last_rise = cyc;
          have_rise = 1;
        end
        if (dout) hi++;
        else if (pd) begin
          chk("high_width_legal", int'(hi == T0H || hi == T1H), 1);
          sh = {sh[6:0], hi == T1H};
          hi = 0;
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (q.size() == 0) chk("scoreboard_empty", 1, 0);
            else chk("byte", sh, q.pop_front());
          end
        end
        if (frame_done) begin
          have_rise = 0;
          chk("sb_drained", q.size(), 0);
        end
        pd = dout;
      end
    end
  end
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 20000);
    if (!frame_done) chk("frame_done_timeout", 0, 1);
  endtask
  initial begin
    int n;
    rst = 0;
    trigger = 1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_dout", dout, 0);
      chk("rst_req", data_request, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
    end
    @(posedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("req_after_release", data_request, 1);
    wait_done();
    chk("busy_last_latch", busy, 1);
    chk("no_req_in_done", data_request, 0);
    @(negedge clk);
    chk("retrigger_req", data_request, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk);
    #2 trigger = 0;
    wait_done();
    repeat (50) @(negedge clk);
    chk("idle_req", data_request, 0);
    chk("idle_dout", dout, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    #2 trigger = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_in_frame < 41 && n < 20000);
    chk("reached_byte40", int'(req_in_frame >= 41), 1);
    repeat (7) @(posedge clk);
    #2 chk("dout_high_pre_rst", dout, 1);
    #1 rst = 0;
    #1 chk("dout_rst_now", dout, 0);
    chk("busy_rst_now", busy, 0);
    chk("req_rst_now", data_request, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("restart_req", data_request, 1);
    wait_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
